// File: rtl/mmio_uart_pkg.sv
// Shared definitions for the MIPS MMIO UART bridge: register offsets, STATUS
// bit positions and the TX drain state encoding.
package mmio_uart_pkg;

    localparam logic [4:0] OFF_TXDATA = 5'h00;
    localparam logic [4:0] OFF_RXDATA = 5'h04;
    localparam logic [4:0] OFF_STATUS = 5'h08;
    localparam logic [4:0] OFF_CTRL   = 5'h0C;
    localparam logic [4:0] OFF_GPIO   = 5'h10;

    localparam int unsigned ST_RX_NOT_EMPTY = 0;
    localparam int unsigned ST_TX_FULL      = 1;
    localparam int unsigned ST_TX_EMPTY     = 2;
    localparam int unsigned ST_RX_OVERRUN   = 3;
    localparam int unsigned ST_TX_DROP      = 4;
    localparam int unsigned ST_DRAIN_BUSY   = 5;
    localparam int unsigned ST_RX_COUNT_LSB = 8;
    localparam int unsigned ST_TX_COUNT_LSB = 16;
    localparam int unsigned CNT_FIELD_W     = 8;

    localparam int unsigned CTRL_CLR_OVERRUN = 0;
    localparam int unsigned CTRL_CLR_DROP    = 1;

    typedef enum logic [1:0] {
        DRAIN_IDLE    = 2'd0,
        DRAIN_START   = 2'd1,
        DRAIN_WAIT_HI = 2'd2,
        DRAIN_WAIT_LO = 2'd3
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with combinational head; a push into a full FIFO is
// accepted only when a pop frees the head slot on the same edge.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/mmio_uart_bridge.sv
// Word-addressed MMIO bridge from the MIPS data port to UART TX/RX FIFOs and a
// GPIO latch, with a drain FSM that feeds the UART transmitter on its own.
module mmio_uart_bridge
    import mmio_uart_pkg::*;
#(
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           UART_Nbit  = 8,
    parameter int unsigned           FIFO_DEPTH = 8,
    parameter logic [DATA_WIDTH-1:0] BASE_ADDR  = 32'h1001_0000,
    parameter int unsigned           GPIO_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  we,
    input  logic                  re,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  hit,
    output logic [UART_Nbit-1:0]  tx_data,
    output logic                  tx_start,
    input  logic                  tx_busy,
    input  logic [UART_Nbit-1:0]  rx_data,
    input  logic                  rx_valid,
    output logic [GPIO_WIDTH-1:0] gpio_data_out,
    output logic                  irq
);

    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    drain_state_t          state;
    logic [4:0]            offset;
    logic                  wr_en;
    logic                  rd_en;
    logic                  tx_push;
    logic                  tx_pop;
    logic                  rx_pop;
    logic                  ctrl_wr;
    logic                  gpio_wr;
    logic [UART_Nbit-1:0]  tx_head;
    logic [UART_Nbit-1:0]  rx_head;
    logic                  tx_full;
    logic                  tx_empty;
    logic                  rx_full;
    logic                  rx_empty;
    logic [CW-1:0]         tx_count;
    logic [CW-1:0]         rx_count;
    logic                  rx_overrun;
    logic                  tx_drop;
    logic                  rx_overrun_set;
    logic                  tx_drop_set;
    logic [DATA_WIDTH-1:0] status;
    logic                  unused_wdata;

    assign hit    = (addr[DATA_WIDTH-1:5] == BASE_ADDR[DATA_WIDTH-1:5]) && (addr[1:0] == 2'b00);
    assign offset = addr[4:0];
    assign wr_en  = we && hit;
    assign rd_en  = re && hit;

    assign tx_push = wr_en && (offset == OFF_TXDATA);
    assign ctrl_wr = wr_en && (offset == OFF_CTRL);
    assign gpio_wr = wr_en && (offset == OFF_GPIO);
    assign rx_pop  = rd_en && (offset == OFF_RXDATA);
    assign tx_pop  = (state == DRAIN_START);

    // A drain or CPU pop on the same edge makes room, so only then is a full push safe.
    assign tx_drop_set    = tx_push && tx_full && !tx_pop;
    assign rx_overrun_set = rx_valid && rx_full && !rx_pop;

    assign irq          = (rx_count != '0) || rx_overrun;
    assign unused_wdata = ^wdata;

    sync_fifo #(
        .WIDTH (UART_Nbit),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (tx_push),
        .pop   (tx_pop),
        .din   (wdata[UART_Nbit-1:0]),
        .dout  (tx_head),
        .full  (tx_full),
        .empty (tx_empty),
        .count (tx_count)
    );

    sync_fifo #(
        .WIDTH (UART_Nbit),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (rx_valid),
        .pop   (rx_pop),
        .din   (rx_data),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty),
        .count (rx_count)
    );

    always_comb begin
        status = '0;
        status[ST_RX_NOT_EMPTY] = !rx_empty;
        status[ST_TX_FULL]      = tx_full;
        status[ST_TX_EMPTY]     = tx_empty;
        status[ST_RX_OVERRUN]   = rx_overrun;
        status[ST_TX_DROP]      = tx_drop;
        status[ST_DRAIN_BUSY]   = (state != DRAIN_IDLE);
        status[ST_RX_COUNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(rx_count);
        status[ST_TX_COUNT_LSB +: CNT_FIELD_W] = CNT_FIELD_W'(tx_count);
    end

    always_comb begin
        rdata = '0;
        if (hit) begin
            case (offset)
                OFF_RXDATA: if (!rx_empty) rdata = DATA_WIDTH'(rx_head);
                OFF_STATUS: rdata = status;
                OFF_GPIO:   rdata = DATA_WIDTH'(gpio_data_out);
                default:    rdata = '0;
            endcase
        end
    end

    // Sticky flags: a set on the same edge as a CTRL clear wins.
    always_ff @(posedge clk) begin
        if (reset) begin
            rx_overrun    <= 1'b0;
            tx_drop       <= 1'b0;
            gpio_data_out <= '0;
        end else begin
            if (rx_overrun_set) begin
                rx_overrun <= 1'b1;
            end else if (ctrl_wr && wdata[CTRL_CLR_OVERRUN]) begin
                rx_overrun <= 1'b0;
            end
            if (tx_drop_set) begin
                tx_drop <= 1'b1;
            end else if (ctrl_wr && wdata[CTRL_CLR_DROP]) begin
                tx_drop <= 1'b0;
            end
            if (gpio_wr) begin
                gpio_data_out <= wdata[GPIO_WIDTH-1:0];
            end
        end
    end

    // Drain: launch one byte, then wait for the UART busy pulse to rise and fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= DRAIN_IDLE;
            tx_start <= 1'b0;
            tx_data  <= '0;
        end else begin
            tx_start <= 1'b0;
            case (state)
                DRAIN_IDLE: begin
                    if (tx_count != '0) begin
                        state    <= DRAIN_START;
                        tx_start <= 1'b1;
                        tx_data  <= tx_head;
                    end
                end
                DRAIN_START: begin
                    state <= DRAIN_WAIT_HI;
                end
                DRAIN_WAIT_HI: begin
                    if (tx_busy) begin
                        state <= DRAIN_WAIT_LO;
                    end
                end
                DRAIN_WAIT_LO: begin
                    if (!tx_busy) begin
                        state <= DRAIN_IDLE;
                    end
                end
                default: begin
                    state <= DRAIN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmio_uart_bridge.sv
// Randomised bench for mmio_uart_bridge against a queue-based model of the
// register map, FIFOs, sticky flags and transmitted byte stream.
module tb_mmio_uart_bridge;

    localparam logic [31:0] BASE  = 32'h1001_0000;
    localparam int          DEPTH = 8;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [31:0] rdata;
    logic        hit;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  gpio_data_out;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;

    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    logic [7:0] got_tx[$];
    bit         rx_ovr;
    bit         tx_drp;
    logic [7:0] gpio_m;

    bit         auto_busy;
    bit         busy_hold;
    int         busy_len;
    int         busy_cnt;
    logic       prev_start;

    mmio_uart_bridge dut (
        .clk           (clk),
        .reset         (reset),
        .addr          (addr),
        .wdata         (wdata),
        .we            (we),
        .re            (re),
        .rdata         (rdata),
        .hit           (hit),
        .tx_data       (tx_data),
        .tx_start      (tx_start),
        .tx_busy       (tx_busy),
        .rx_data       (rx_data),
        .rx_valid      (rx_valid),
        .gpio_data_out (gpio_data_out),
        .irq           (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // UART transmitter stand-in: busy for busy_len cycles after each start pulse.
    assign tx_busy = busy_hold || (busy_cnt != 0);
    always @(posedge clk) begin
        if (auto_busy && tx_start) busy_cnt <= busy_len;
        else if (busy_cnt != 0)    busy_cnt <= busy_cnt - 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (tx_start) begin
            check("txstart_one_cycle", 32'(prev_start), 32'd0);
            got_tx.push_back(tx_data);
        end
        prev_start = tx_start;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic logic [31:0] exp_status(input int txn, input bit dbusy);
        logic [31:0] s;
        s        = '0;
        s[0]     = (rx_q.size() != 0);
        s[1]     = (txn == DEPTH);
        s[2]     = (txn == 0);
        s[3]     = rx_ovr;
        s[4]     = tx_drp;
        s[5]     = dbusy;
        s[15:8]  = 8'(rx_q.size());
        s[23:16] = 8'(txn);
        return s;
    endfunction

    task automatic bus_write(input logic [7:0] off, input logic [31:0] d);
        @(negedge clk);
        addr  = BASE + 32'(off);
        wdata = d;
        we    = 1'b1;
        @(posedge clk);
        #1;
        we    = 1'b0;
        addr  = BASE + 32'h100;
    endtask

    task automatic bus_read(input logic [7:0] off, output logic [31:0] d);
        @(negedge clk);
        addr = BASE + 32'(off);
        re   = 1'b1;
        #1;
        d    = rdata;
        @(posedge clk);
        #1;
        re   = 1'b0;
        addr = BASE + 32'h100;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        if (rx_q.size() < DEPTH) rx_q.push_back(b);
        else                     rx_ovr = 1'b1;
    endtask

    task automatic rd_rx_check(input string tag);
        logic [31:0] d;
        logic [31:0] e;
        e = '0;
        if (rx_q.size() != 0) e = 32'(rx_q.pop_front());
        bus_read(8'h04, d);
        check(tag, d, e);
    endtask

    task automatic check_status(input string tag, input int txn, input bit dbusy);
        logic [31:0] d;
        bus_read(8'h08, d);
        check(tag, d, exp_status(txn, dbusy));
        check({tag, "_irq"}, 32'(irq), 32'((rx_q.size() != 0) || rx_ovr));
    endtask

    task automatic wait_drain();
        logic [31:0] d;
        bit done;
        done = 1'b0;
        for (int i = 0; i < 400 && !done; i++) begin
            bus_read(8'h08, d);
            done = d[2] && !d[5];
        end
        check("drain_done", 32'(done), 32'd1);
    endtask

    task automatic compare_tx(input string tag);
        check({tag, "_count"}, 32'(got_tx.size()), 32'(exp_tx.size()));
        for (int i = 0; i < exp_tx.size(); i++) begin
            if (i < got_tx.size()) check({tag, "_byte"}, 32'(got_tx[i]), 32'(exp_tx[i]));
        end
        got_tx.delete();
        exp_tx.delete();
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  b;
        logic [1:0]  m;
        int          n;

        reset = 1'b1; addr = BASE + 32'h100; wdata = '0; we = 1'b0; re = 1'b0;
        rx_data = '0; rx_valid = 1'b0;
        auto_busy = 1'b0; busy_hold = 1'b0; busy_len = 10; busy_cnt = 0;
        prev_start = 1'b0; rx_ovr = 1'b0; tx_drp = 1'b0; gpio_m = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_tx_start", 32'(tx_start), 32'd0);
        check("rst_tx_data", 32'(tx_data), 32'd0);
        check("rst_gpio", 32'(gpio_data_out), 32'd0);
        check("rst_irq", 32'(irq), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        bus_read(8'h08, d);
        check("rst_status", d, 32'h0000_0004);

        // Two bytes through the drain, first-byte latency checked exactly
        got_tx.delete();
        auto_busy = 1'b1; busy_len = 10;
        bus_write(8'h00, 32'h41); exp_tx.push_back(8'h41);
        check("lat_idle_cycle", 32'(tx_start), 32'd0);
        @(posedge clk); #1;
        check("lat_start", 32'(tx_start), 32'd1);
        check("lat_data", 32'(tx_data), 32'h41);
        bus_write(8'h00, 32'h42); exp_tx.push_back(8'h42);
        wait_drain();
        compare_tx("two_bytes");
        check_status("two_bytes_st", 0, 1'b0);

        // TX overflow with the transmitter stuck busy
        auto_busy = 1'b0; busy_hold = 1'b1;
        for (int i = 0; i < 9; i++) begin
            b = 8'($urandom);
            exp_tx.push_back(b);
            bus_write(8'h00, 32'(b));
        end
        bus_write(8'h00, 32'hEE);
        tx_drp = 1'b1;
        check_status("tx_ovf_st", DEPTH, 1'b1);
        check("tx_ovf_sent", 32'(got_tx.size()), 32'd1);
        bus_write(8'h0C, 32'h2);
        tx_drp = 1'b0;
        check_status("tx_drop_clr", DEPTH, 1'b1);
        busy_hold = 1'b0; auto_busy = 1'b1; busy_len = 3;
        wait_drain();
        compare_tx("tx_ovf");

        // RX overrun, drain by reads, clear
        for (int i = 0; i < 9; i++) rx_pulse(8'(8'h10 + i));
        check_status("rx_ovf_st", 0, 1'b0);
        for (int i = 0; i < 9; i++) rd_rx_check("rx_ovf_rd");
        check_status("rx_empty_st", 0, 1'b0);
        bus_write(8'h0C, 32'h1);
        rx_ovr = 1'b0;
        check_status("rx_ovr_clr", 0, 1'b0);

        // RX full with a byte arriving on the same edge as a pop
        for (int i = 0; i < DEPTH; i++) rx_pulse(8'($urandom));
        @(negedge clk);
        addr = BASE + 32'h04; re = 1'b1; rx_data = 8'h55; rx_valid = 1'b1;
        #1;
        d = rdata;
        @(posedge clk); #1;
        re = 1'b0; rx_valid = 1'b0; addr = BASE + 32'h100;
        check("rx_coinc_rd", d, 32'(rx_q.pop_front()));
        rx_q.push_back(8'h55);
        check_status("rx_coinc_st", 0, 1'b0);
        for (int i = 0; i < DEPTH; i++) rd_rx_check("rx_coinc_drain");

        // GPIO and address decode
        bus_write(8'h10, 32'hFFFF_FFA5); gpio_m = 8'hA5;
        bus_read(8'h10, d);
        check("gpio_rd", d, 32'(gpio_m));
        check("gpio_pin", 32'(gpio_data_out), 32'(gpio_m));
        bus_write(8'h12, 32'h0000_00FF);
        check("gpio_misaligned", 32'(gpio_data_out), 32'(gpio_m));
        bus_write(8'h01, 32'h0000_0077);
        check_status("tx_misaligned", 0, 1'b0);
        @(negedge clk);
        addr = BASE + 32'h2;  #1; check("hit_misaligned", 32'(hit), 32'd0);
        addr = BASE + 32'h10; #1; check("hit_gpio", 32'(hit), 32'd1);
        addr = BASE + 32'h20; #1; check("hit_outside", 32'(hit), 32'd0);
        addr = BASE + 32'h100;
        bus_read(8'h14, d);
        check("rd_unmapped", d, 32'd0);
        bus_read(8'h00, d);
        check("rd_txdata", d, 32'd0);

        // Randomised mix of RX traffic, TX bursts, GPIO and flag clears
        for (int r = 0; r < 14; r++) begin
            case ($urandom_range(0, 3))
                0: begin
                    n = $urandom_range(1, 10);
                    for (int i = 0; i < n; i++) rx_pulse(8'($urandom));
                end
                1: begin
                    n = $urandom_range(1, 10);
                    for (int i = 0; i < n; i++) rd_rx_check("rnd_rx_rd");
                end
                2: begin
                    n = $urandom_range(1, DEPTH);
                    busy_len = $urandom_range(1, 6);
                    auto_busy = 1'b1;
                    for (int i = 0; i < n; i++) begin
                        b = 8'($urandom);
                        exp_tx.push_back(b);
                        bus_write(8'h00, (32'($urandom) & 32'hFFFF_FF00) | 32'(b));
                    end
                    wait_drain();
                    compare_tx("rnd_tx");
                end
                default: begin
                    b = 8'($urandom);
                    bus_write(8'h10, 32'(b));
                    gpio_m = b;
                    bus_read(8'h10, d);
                    check("rnd_gpio", d, 32'(gpio_m));
                    m = 2'($urandom);
                    bus_write(8'h0C, 32'(m));
                    if (m[0]) rx_ovr = 1'b0;
                    if (m[1]) tx_drp = 1'b0;
                end
            endcase
            check_status("rnd_st", 0, 1'b0);
        end

        // Reset while the drain waits for tx_busy to rise
        auto_busy = 1'b0; busy_hold = 1'b0;
        bus_write(8'h10, 32'h3C); gpio_m = 8'h3C;
        rx_pulse(8'h99);
        bus_write(8'h00, 32'h77);
        @(posedge clk);
        @(posedge clk);
        bus_read(8'h08, d);
        check("waithi_st", d, exp_status(0, 1'b1));
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("midrst_tx_start", 32'(tx_start), 32'd0);
        check("midrst_tx_data", 32'(tx_data), 32'd0);
        check("midrst_gpio", 32'(gpio_data_out), 32'd0);
        check("midrst_irq", 32'(irq), 32'd0);
        reset = 1'b0;
        rx_q.delete(); rx_ovr = 1'b0; tx_drp = 1'b0; gpio_m = '0;
        got_tx.delete();
        check_status("midrst_st", 0, 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
